// File: rtl/cache_line_fill.sv
// cache_line_fill
//   Miss-side engine for the 2-way set-associative cache. On a miss it
//   optionally writes the dirty victim line back to physical memory, fetches
//   the requested 128-bit line and installs tag/data into the chosen way.
//
//   Address split (16-bit): tag [15:7], index [6:4], offset [3:0].
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   miss_req/miss_addr  miss request and its address (sampled only in IDLE)
//   lru_way             way to replace
//   victim_*            valid/dirty/tag/data of the line in lru_way
//   pmem_*              physical-memory port (read/write request, address,
//                       write data, read data, one-cycle response)
//   fill_*              array write port (strobe, way, index, tag, line)
//   fill_done           one-cycle pulse after the install
//   busy                high whenever the engine is not IDLE
//   state_dbg           current FSM state encoding, for checkers
//
// Memory handshake: a request (pmem_read or pmem_write) is raised on entry to
// WRITEBACK/FETCH and held with a stable address/wdata until memory answers
// with a one-cycle pmem_resp; the response completes exactly that request and
// the request drops on the following cycle. Read and write are never high
// together. A pmem_resp with no request outstanding is ignored.
module cache_line_fill #(
  parameter int TAG_W  = 9,
  parameter int IDX_W  = 3,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_req,
  input  logic [15:0]       miss_addr,
  input  logic              lru_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic [LINE_W-1:0] victim_data,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              fill_we,
  output logic              fill_way,
  output logic [IDX_W-1:0]  fill_index,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [LINE_W-1:0] fill_data,
  output logic              fill_done,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam int OFF_W = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITEBACK = 3'd1,
    S_FETCH     = 3'd2,
    S_INSTALL   = 3'd3,
    S_RETIRE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [IDX_W-1:0]   idx_q;
  logic               way_q;
  logic [TAG_W-1:0]   vtag_q;
  logic [LINE_W-1:0]  vdata_q;
  logic [LINE_W-1:0]  line_q;

  // Offset bits select a word inside the line and never leave this block.
  logic unused_offset;
  assign unused_offset = ^miss_addr[OFF_W-1:0];

  // An invalid line carries stale data, so its dirty bit is meaningless.
  logic need_wb;
  assign need_wb = victim_valid & victim_dirty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      way_q   <= 1'b0;
      vtag_q  <= '0;
      vdata_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      // Everything the transfer needs is captured at accept; the requester
      // and the arrays may change underneath us afterwards.
      if (state_q == S_IDLE && miss_req) begin
        tag_q   <= miss_addr[OFF_W+IDX_W +: TAG_W];
        idx_q   <= miss_addr[OFF_W +: IDX_W];
        way_q   <= lru_way;
        vtag_q  <= victim_tag;
        vdata_q <= victim_data;
      end
      if (state_q == S_FETCH && pmem_resp) begin
        line_q <= pmem_rdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    fill_we      = 1'b0;
    fill_way     = 1'b0;
    fill_index   = '0;
    fill_tag     = '0;
    fill_data    = '0;
    fill_done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          state_d = need_wb ? S_WRITEBACK : S_FETCH;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {vtag_q, idx_q, {OFF_W{1'b0}}};
        pmem_wdata   = vdata_q;
        if (pmem_resp) state_d = S_FETCH;
      end
      S_FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {tag_q, idx_q, {OFF_W{1'b0}}};
        if (pmem_resp) state_d = S_INSTALL;
      end
      S_INSTALL: begin
        fill_we    = 1'b1;
        fill_way   = way_q;
        fill_index = idx_q;
        fill_tag   = tag_q;
        fill_data  = line_q;
        state_d    = S_RETIRE;
      end
      S_RETIRE: begin
        // The requester observes the hit now; miss_req is deliberately not
        // looked at until we are back in IDLE.
        fill_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed testbench for cache_line_fill. Inputs are driven and outputs are
// sampled on the falling clock edge; installs are checked by a monitor against
// an expected queue filled by the driver.
module tb_cache_line_fill;

  localparam int TAG_W  = 9;
  localparam int IDX_W  = 3;
  localparam int LINE_W = 128;
  localparam int FILL_W = 1 + IDX_W + TAG_W + LINE_W;

  logic              clk;
  logic              rst_n;
  logic              miss_req;
  logic [15:0]       miss_addr;
  logic              lru_way;
  logic              victim_valid;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] victim_data;
  logic              pmem_read;
  logic              pmem_write;
  logic [15:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              fill_we;
  logic              fill_way;
  logic [IDX_W-1:0]  fill_index;
  logic [TAG_W-1:0]  fill_tag;
  logic [LINE_W-1:0] fill_data;
  logic              fill_done;
  logic              busy;
  logic [2:0]        state_dbg;

  cache_line_fill #(.TAG_W(TAG_W), .IDX_W(IDX_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req), .miss_addr(miss_addr), .lru_way(lru_way),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_data(victim_data),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .fill_we(fill_we), .fill_way(fill_way), .fill_index(fill_index),
    .fill_tag(fill_tag), .fill_data(fill_data),
    .fill_done(fill_done), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [FILL_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (rst_n && fill_we) begin
      if (exp_q.size() == 0) check("fill_unexpected", 160'(fill_we), 160'(0));
      else check("fill_contents", 160'({fill_way, fill_index, fill_tag, fill_data}),
                 160'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    miss_req = 1'b0; miss_addr = '0; lru_way = 1'b0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0; victim_data = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
  endtask

  // Starts at a falling edge with the DUT idle and ends at a falling edge with
  // the DUT back in IDLE. All expected values are supplied by the caller.
  task automatic do_miss(
    input logic [15:0] addr, input logic way,
    input logic vvalid, input logic vdirty,
    input logic [TAG_W-1:0] vtag, input logic [LINE_W-1:0] vdata,
    input int wlat, input int rlat, input logic [LINE_W-1:0] rdata,
    input logic exp_wb, input logic [15:0] exp_wb_addr, input logic [15:0] exp_rd_addr,
    input logic [TAG_W-1:0] exp_tag, input logic [IDX_W-1:0] exp_idx,
    input logic disturb, input logic keep_req);
    miss_req = 1'b1; miss_addr = addr; lru_way = way;
    victim_valid = vvalid; victim_dirty = vdirty; victim_tag = vtag; victim_data = vdata;
    exp_q.push_back({way, exp_idx, exp_tag, rdata});
    @(negedge clk);
    if (exp_wb) begin
      for (int i = 1; i <= wlat; i++) begin
        check("wb_write", 160'(pmem_write), 160'(1));
        check("wb_no_read", 160'(pmem_read), 160'(0));
        check("wb_addr", 160'(pmem_address), 160'(exp_wb_addr));
        check("wb_wdata", 160'(pmem_wdata), 160'(vdata));
        pmem_resp = (i == wlat);
        @(negedge clk);
        pmem_resp = 1'b0;
      end
    end
    for (int i = 1; i <= rlat; i++) begin
      check("rd_read", 160'(pmem_read), 160'(1));
      check("rd_no_write", 160'(pmem_write), 160'(0));
      check("rd_addr", 160'(pmem_address), 160'(exp_rd_addr));
      if (disturb && i == 1) begin
        miss_addr = ~addr; lru_way = ~way;
        victim_tag = ~vtag; victim_data = ~vdata;
      end
      pmem_resp  = (i == rlat);
      pmem_rdata = (i == rlat) ? rdata : ~rdata;
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
    end
    check("install_we", 160'(fill_we), 160'(1));
    check("install_no_req", 160'({pmem_read, pmem_write, fill_done}), 160'(0));
    @(negedge clk);
    // Reaching RETIRE here confirms latency wlat+rlat+2 cycles after accept.
    check("retire_done", 160'(fill_done), 160'(1));
    check("retire_busy_we", 160'({busy, fill_we}), 160'(2'b10));
    if (!keep_req) miss_req = 1'b0;
    @(negedge clk);
    check("back_idle", 160'({busy, fill_done, state_dbg}), 160'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_strobes", 160'({pmem_read, pmem_write, fill_we, fill_done, busy, state_dbg}), 160'(0));
    check("reset_addr_tag", 160'({pmem_address, fill_way, fill_index, fill_tag}), 160'(0));
    check("reset_wdata", 160'(pmem_wdata), 160'(0));
    check("reset_fdata", 160'(fill_data), 160'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Clean miss, invalid victim.
    do_miss(16'h1234, 1'b1, 1'b0, 1'b0, 9'h000, '0, 0, 3, {16{8'hA5}},
            1'b0, 16'h0000, 16'h1230, 9'h024, 3'd3, 1'b0, 1'b0);
    // Dirty miss with writeback.
    do_miss(16'h1234, 1'b0, 1'b1, 1'b1, 9'h1FF, {16{8'h0F}}, 2, 1, {16{8'h3C}},
            1'b1, 16'hFFB0, 16'h1230, 9'h024, 3'd3, 1'b0, 1'b0);
    // Invalid but dirty victim: straight to fetch.
    do_miss(16'hABCD, 1'b0, 1'b0, 1'b1, 9'h055, {8{16'hBEEF}}, 0, 2,
            128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
            1'b0, 16'h0000, 16'hABC0, 9'h157, 3'd4, 1'b0, 1'b0);
    // Inputs disturbed during fetch: latched values must win.
    do_miss(16'h0F7E, 1'b1, 1'b1, 1'b0, 9'h0AA, {4{32'hCAFE_F00D}}, 0, 4,
            {4{32'h1357_9BDF}}, 1'b0, 16'h0000, 16'h0F70, 9'h01E, 3'd7, 1'b1, 1'b0);

    // Reset in the middle of a writeback.
    miss_req = 1'b1; miss_addr = 16'h5550; lru_way = 1'b1;
    victim_valid = 1'b1; victim_dirty = 1'b1; victim_tag = 9'h123; victim_data = {16{8'h77}};
    @(negedge clk);
    check("rst_wb_active", 160'(pmem_write), 160'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_wb_drop", 160'({pmem_write, pmem_read, fill_we, busy}), 160'(0));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_released_idle", 160'({busy, state_dbg}), 160'(0));
    do_miss(16'h8000, 1'b0, 1'b1, 1'b1, 9'h001, {8{16'h4242}}, 1, 1, {8{16'h9999}},
            1'b1, 16'h0080, 16'h8000, 9'h100, 3'd0, 1'b0, 1'b0);

    // Spurious response while idle.
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("spurious_resp", 160'({busy, pmem_read, pmem_write, state_dbg}), 160'(0));
    @(negedge clk);
    check("spurious_still_idle", 160'({busy, fill_we, fill_done}), 160'(0));

    // Back-to-back: request held through RETIRE, next fill starts from IDLE.
    do_miss(16'h4567, 1'b0, 1'b1, 1'b0, 9'h033, '0, 0, 2, {8{16'h6666}},
            1'b0, 16'h0000, 16'h4560, 9'h08A, 3'd6, 1'b0, 1'b1);
    do_miss(16'h7FF0, 1'b1, 1'b1, 1'b1, 9'h1AA, {16{8'hE1}}, 3, 2, {16{8'h5A}},
            1'b1, 16'hD570, 16'h7FF0, 9'h0FF, 3'd7, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("all_fills_seen", 160'(exp_q.size()), 160'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Miss-side companion to the 2-way set-associative cache's tag-compare/read path.
- When the compare path reports a miss, this block does the following in order:
  - writes back a dirty victim line to physical memory, if needed;
  - fetches the requested 128-bit line;
  - installs the new line's tag, data and valid bit into the selected way.
- Sits between the cache datapath arrays and the physical-memory port.
- Address split (16-bit): tag [15:7], index [6:4], offset [3:0].

Parameters:
- TAG_W, 9, tag width
- IDX_W, 3, set-index width
- LINE_W, 128, line width in bits

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_req  in  1  miss pending; held high by the requester until it sees a hit
- miss_addr  in  16  address of the missing access
- lru_way  in  1  way to replace (0/1)
- victim_valid  in  1  valid bit of the line in lru_way at miss_addr's index
- victim_dirty  in  1  dirty bit of that line
- victim_tag  in  TAG_W  tag of that line
- victim_data  in  LINE_W  data of that line
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_address  out  16  line-aligned memory address
- pmem_wdata  out  LINE_W  writeback data
- pmem_rdata  in  LINE_W  read data, valid when pmem_resp=1
- pmem_resp  in  1  one-cycle completion for the current request
- fill_we  out  1  write strobe into the tag/data/valid/dirty arrays
- fill_way  out  1  way being written
- fill_index  out  IDX_W  set being written
- fill_tag  out  TAG_W  tag to install
- fill_data  out  LINE_W  line to install
- fill_done  out  1  one-cycle pulse: install complete
- busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, WRITEBACK, FETCH, INSTALL, RETIRE.
- Reset (async, rst_n=0):
  - state=IDLE; all internal registers cleared;
  - all outputs 0 (pmem_read, pmem_write, fill_we, fill_done, busy, pmem_address, pmem_wdata, fill_*).
  - Asserting reset mid-transfer drops pmem_read/pmem_write immediately. No array write occurs.
- IDLE:
  - On miss_req=1, latch the request and go to a transfer state:
    - latched: miss_addr tag/index, lru_way, victim_tag, victim_data;
    - to WRITEBACK if victim_valid & victim_dirty;
    - otherwise to FETCH (an invalid line is never written back, even if its dirty bit is set).
  - pmem_resp received in IDLE is ignored.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim_tag, index, 4'b0}, pmem_wdata=latched victim_data.
  - Outputs are held stable until pmem_resp=1; then go to FETCH.
- FETCH:
  - pmem_read=1, pmem_address={miss tag, index, 4'b0}.
  - Held until pmem_resp=1; then capture pmem_rdata and go to INSTALL.
- pmem_read and pmem_write are never high together.
- INSTALL (exactly 1 cycle):
  - fill_we=1, fill_way=latched lru_way, fill_index=latched index, fill_tag=latched tag, fill_data=captured line.
  - The arrays set valid=1 and dirty=0 on fill_we.
  - Next state RETIRE.
- RETIRE (exactly 1 cycle):
  - fill_done=1; the requester sees a hit this cycle and drops miss_req.
  - Next state IDLE.
  - miss_req is not sampled in RETIRE.
- Input handling:
  - miss_req, miss_addr and victim_* changes while busy are ignored; all latched values are used.
  - Offset bits of miss_addr never reach pmem_address.
- Latency:
  - clean miss with memory latency N cycles (resp in Nth FETCH cycle): fill_done N+2 cycles after the accept edge;
  - dirty miss with write latency M: add M cycles.
- If miss_req is still high in the IDLE cycle after RETIRE, a new fill starts (requester error, not masked).

Test Plan:
- Clean miss, addr 16'h1234, lru_way=1, victim_valid=0, read resp after 3 cycles with rdata=128'hA5..A5:
  - pmem_read with address 16'h1230, no pmem_write;
  - fill_we with way=1, index=3, tag=9'h024, data A5..A5;
  - fill_done one cycle later.
- Dirty miss, victim_tag=9'h1FF, index=3, victim_data=128'h0F..0F:
  - pmem_write with address 16'hFFB0 and wdata 0F..0F held until resp;
  - then pmem_read with address 16'h1230;
  - then install.
- victim_valid=0, victim_dirty=1 -> no writeback; goes directly to FETCH.
- Change miss_addr and lru_way during FETCH -> installed tag/way/index match the values latched at accept.
- rst_n=0 mid-WRITEBACK -> pmem_write falls immediately, no fill_we; after release, busy=0 and a new miss_req is accepted normally.
- Spurious pmem_resp in IDLE -> no state change; fill_done pulse exactly 1 cycle wide; back-to-back misses separated by RETIRE.
